if_fetch_stage: RTL

Instruction-fetch stage: owns the PC register, next-PC selection and the IF/ID pipeline register. It is the consumer of the hazard unit's stall/flush controls, and applies them to PC and IF/ID state each cycle. It also resolves ID-stage jumps (j/jal/jr/jalr) and EX-stage taken branches. Instruction memory sits outside the block, with an asynchronous read.

---
 rtl/mips_pkg.sv | 19 +
 rtl/sat_counter.sv | 24 ++
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants for the front-end pipeline stages.
package mips_pkg;

    // Primary opcodes (instr[31:26]) that the fetch stage decodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (instr[5:0]) for register jumps.
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    // An all-zero word is sll $0,$0,0. It is the bubble loaded on a flush.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default boot address.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Clear on reset; otherwise count up until every bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. It holds the PC, selects the next PC, and owns the
// IF/ID register. Stall and flush controls come from the hazard unit.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             if_flush_n,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jr_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_is_j;
    logic        w_is_jr;
    logic [31:0] w_jump_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_pc;
    logic [31:0] w_jr_pc;
    logic [31:0] w_pc_next;
    logic        w_ifid_flush;
    logic        w_stall_inc;
    logic        w_flush_inc;

    assign w_opcode   = r_instr[31:26];
    assign w_funct    = r_instr[5:0];
    assign w_pc_plus4 = r_pc + 32'd4;   // wraps naturally at 2^32

    // Redirect targets are forced to word alignment.
    assign w_branch_pc = branch_target & 32'hFFFF_FFFC;
    assign w_jr_pc     = jr_target     & 32'hFFFF_FFFC;

    // Jumps are decoded only from a real instruction in ID. A flushed slot
    // holds a NOP, and a NOP is also an R-type with funct 0.
    assign w_is_j  = r_valid && ((w_opcode == OP_J) || (w_opcode == OP_JAL));
    assign w_is_jr = r_valid && (w_opcode == OP_RTYPE) &&
                     ((w_funct == FN_JR) || (w_funct == FN_JALR));

    // Select the jump target: absolute (j/jal) or register (jr/jalr).
    always_comb begin
        w_jump_target = w_jr_pc;
        if (w_is_j) begin
            w_jump_target = {r_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end
    end

    // Next-PC priority: taken branch, then stall hold, then ID jump, then
    // sequential fetch. A branch redirects even while the PC is stalled.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (branch_taken) begin
            w_pc_next = w_branch_pc;
        end else if (!pc_write) begin
            w_pc_next = r_pc;
        end else if (w_is_j || w_is_jr) begin
            w_pc_next = w_jump_target;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // A write-disabled IF/ID keeps a pending jump, so its flush lands on the
    // first cycle the stall is released.
    assign w_ifid_flush = branch_taken || (if_id_write && !if_flush_n);

    // IF/ID register: flush, hold, or capture the fetched word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (w_ifid_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (if_id_write) begin
            r_instr    <= imem_rdata;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign w_stall_inc = !pc_write && !branch_taken;
    assign w_flush_inc = w_ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

    assign imem_addr      = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus4 = r_pc_plus4;
    assign if_id_valid    = r_valid;

endmodule
